// File: rtl/counter_pkg.sv
// Shared constants and helpers for the sequential counter library.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int unsigned MODE_WRAP     = 0;
   localparam int unsigned MODE_SATURATE = 1;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((longint'(1) << r) < longint'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Clock-enable prescaler: emits one tick every PRESCALE enabled cycles.
module prescaler_tick
   import counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   // With PRESCALE=1 the phase counter never leaves 0, so tick reduces to en.
   localparam int unsigned PW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt_q;
   logic [PW-1:0] cnt_d;

   // Tick on the last phase of an enabled interval.
   always_comb begin
      tick = en && (cnt_q == LAST);
   end

   // Phase advance: clear on load or tick, hold while disabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + PW'(1);
      end
   end

   // Phase register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load, prescaler and wrap/saturate.
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MODULUS  = 16,
   parameter int unsigned PRESCALE = 1,
   parameter int unsigned SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam longint unsigned RANGE = longint'(1) << WIDTH;
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

   if (MODULUS < 2) begin : g_bad_mod_lo
      $error("updown_mod_counter: MODULUS must be at least 2");
   end
   if (longint'(MODULUS) > RANGE) begin : g_bad_mod_hi
      $error("updown_mod_counter: MODULUS must not exceed 2**WIDTH");
   end
   if (PRESCALE < 1) begin : g_bad_pre
      $error("updown_mod_counter: PRESCALE must be at least 1");
   end

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             tick;
   logic             at_max;
   logic             at_min;

   // Step strobe; a load restarts the prescale interval.
   prescaler_tick #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (load),
      .tick  (tick)
   );

   // Next count: load clamps into range, step wraps or saturates at the ends.
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      at_max = (q_q == MAXV);
      at_min = (q_q == '0);
      if (load) begin
         q_d = (load_val > MAXV) ? MAXV : load_val;
      end else if (tick) begin
         if (up == DIR_UP) begin
            if (!at_max) begin
               q_d = q_q + WIDTH'(1);
            end else if (SATURATE != MODE_SATURATE) begin
               q_d    = '0;
               wrap_d = 1'b1;
            end
         end else begin
            if (!at_min) begin
               q_d = q_q - WIDTH'(1);
            end else if (SATURATE != MODE_SATURATE) begin
               q_d    = MAXV;
               wrap_d = 1'b1;
            end
         end
      end
   end

   // Count and wrap-pulse registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign q    = q_q;
   assign wrap = wrap_q;
   assign tc   = (up == DIR_UP) ? (q_q == MAXV) : (q_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench: three counter configurations against a behavioural model.
module tb_updown_mod_counter;

   logic       clk = 1'b0;
   logic       reset, en, up, load;
   logic [3:0] load_val;
   logic [3:0] qa, qb, qc;
   logic       tca, tcb, tcc, wa, wb, wc;

   always #5 clk = ~clk;

   // A: mod-10 wrap, B: mod-10 saturate, C: mod-16 prescale-3 wrap
   updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_a (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .q(qa), .tc(tca), .wrap(wa));
   updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_b (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .q(qb), .tc(tcb), .wrap(wb));
   updown_mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3), .SATURATE(0)) u_c (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .q(qc), .tc(tcc), .wrap(wc));

   int total = 0;
   int bad   = 0;

   int modv[3] = '{10, 10, 16};
   int prev[3] = '{1, 1, 3};
   int satv[3] = '{0, 1, 0};
   int mq[3]   = '{0, 0, 0};
   int mph[3]  = '{0, 0, 0};
   int mw[3]   = '{0, 0, 0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] dq(input int i);
      case (i)
         0:       return 32'(qa);
         1:       return 32'(qb);
         default: return 32'(qc);
      endcase
   endfunction

   function automatic logic [31:0] dw(input int i);
      case (i)
         0:       return 32'(wa);
         1:       return 32'(wb);
         default: return 32'(wc);
      endcase
   endfunction

   function automatic logic [31:0] dtc(input int i);
      case (i)
         0:       return 32'(tca);
         1:       return 32'(tcb);
         default: return 32'(tcc);
      endcase
   endfunction

   // Terminal count from the model's count and the present direction.
   function automatic int mtc(input int i);
      if (up) return (mq[i] == modv[i] - 1) ? 1 : 0;
      return (mq[i] == 0) ? 1 : 0;
   endfunction

   // Behavioural update of every model at a rising edge.
   task automatic model_edge();
      int m;
      for (int i = 0; i < 3; i++) begin
         m = modv[i];
         mw[i] = 0;
         if (!reset) begin
            mq[i]  = 0;
            mph[i] = 0;
         end else if (load) begin
            mq[i]  = (int'(load_val) > m - 1) ? m - 1 : int'(load_val);
            mph[i] = 0;
         end else if (en) begin
            mph[i] = mph[i] + 1;
            if (mph[i] == prev[i]) begin
               mph[i] = 0;
               if (satv[i] != 0) begin
                  if (up) mq[i] = (mq[i] + 1 > m - 1) ? m - 1 : mq[i] + 1;
                  else    mq[i] = (mq[i] - 1 < 0) ? 0 : mq[i] - 1;
               end else begin
                  mw[i] = up ? int'(mq[i] == m - 1) : int'(mq[i] == 0);
                  mq[i] = (mq[i] + (up ? 1 : m - 1)) % m;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("q[%0d]", i), dq(i), 32'(mq[i]));
         chk($sformatf("wrap[%0d]", i), dw(i), 32'(mw[i]));
         chk($sformatf("tc[%0d]", i), dtc(i), 32'(mtc(i)));
      end
   endtask

   // One clock: model follows the edge, then outputs are checked 1ns later.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic drive(input logic r, input logic e, input logic u,
                        input logic l, input logic [3:0] lv);
      reset = r; en = e; up = u; load = l; load_val = lv;
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      cyc(); cyc();
      chk("lit reset q", 32'(qa), 32'd0);
      chk("lit reset wrap", 32'(wa), 32'd0);
      chk("lit reset tc down", 32'(tca), 32'd1);

      // Count down through the wrap on A.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      cyc();
      chk("lit down wrap q", 32'(qa), 32'd9);
      chk("lit down wrap pulse", 32'(wa), 32'd1);
      cyc();
      chk("lit down q8", 32'(qa), 32'd8);
      chk("lit down pulse gone", 32'(wa), 32'd0);
      repeat (8) cyc();
      chk("lit down q0", 32'(qa), 32'd0);
      chk("lit down tc at 0", 32'(tca), 32'd1);
      cyc();
      chk("lit second wrap q", 32'(qa), 32'd9);
      chk("lit second wrap pulse", 32'(wa), 32'd1);

      // Load with en low, then count up through the top.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd7);
      cyc();
      chk("lit load en0", 32'(qa), 32'd7);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      cyc(); cyc();
      chk("lit up q9", 32'(qa), 32'd9);
      chk("lit up tc at 9", 32'(tca), 32'd1);
      up = 1'b0; #1;
      chk("lit tc drops on up toggle", 32'(tca), 32'd0);
      up = 1'b1; #1;
      cyc();
      chk("lit up wrap q0", 32'(qa), 32'd0);
      chk("lit up wrap pulse", 32'(wa), 32'd1);

      // Out-of-range load clamps; load beats a wrapping step.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd15);
      cyc();
      chk("lit load clamp", 32'(qa), 32'd9);
      chk("lit load 15 mod16", 32'(qc), 32'd15);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
      cyc();
      chk("lit load over step q", 32'(qa), 32'd3);
      chk("lit load over step wrap", 32'(wa), 32'd0);

      // Saturate at the top on B.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd8);
      cyc();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("lit sat hold q", 32'(qb), 32'd9);
         chk("lit sat no wrap", 32'(wb), 32'd0);
         chk("lit sat tc", 32'(tcb), 32'd1);
      end
      up = 1'b0;
      cyc();
      chk("lit sat down", 32'(qb), 32'd8);

      // Reset beats load and step.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
      cyc();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
      cyc();
      chk("lit reset over load q", 32'(qa), 32'd0);
      chk("lit reset over load wrap", 32'(wa), 32'd0);
      chk("lit reset over load qc", 32'(qc), 32'd0);

      // Prescale-3 timing on C, including en gaps and a phase-restarting load.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      cyc(); cyc();
      chk("lit pre hold", 32'(qc), 32'd0);
      cyc();
      chk("lit pre step", 32'(qc), 32'd1);
      cyc();
      en = 1'b0;
      cyc(); cyc();
      en = 1'b1;
      cyc();
      chk("lit pre gap hold", 32'(qc), 32'd1);
      cyc();
      chk("lit pre gap step", 32'(qc), 32'd2);
      cyc();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd4);
      cyc();
      load = 1'b0;
      cyc(); cyc();
      chk("lit pre load phase hold", 32'(qc), 32'd4);
      cyc();
      chk("lit pre load phase step", 32'(qc), 32'd5);

      // Random traffic against the model.
      for (int k = 0; k < 800; k++) begin
         reset    = ($urandom_range(0, 49) != 0);
         load     = ($urandom_range(0, 9) == 0);
         en       = ($urandom_range(0, 9) < 7);
         up       = ($urandom_range(0, 7) < 5) ? (k[6] ^ 1'b1) : k[6];
         load_val = 4'($urandom_range(0, 15));
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
